// File: rtl/sirali_kilit_acici_if.sv
// Move-entry, code-reload and status signals of the sequential combination lock.
// The master side presents moves and codes; the slave side is the lock controller.
interface sirali_kilit_acici_if #(
   parameter int ADIM_SAYISI  = 4,
   parameter int ADIM_W       = 3,
   parameter int DENEME_LIMIT = 3
);
   localparam int HAMLE_W   = ADIM_W + 1;
   localparam int SIFRE_W   = ADIM_SAYISI * HAMLE_W;
   localparam int ADIM_NO_W = $clog2(ADIM_SAYISI + 1);
   localparam int KALAN_W   = $clog2(DENEME_LIMIT + 1);

   logic                 adim_gecerli;
   logic                 yon;
   logic [ADIM_W-1:0]    adim;
   logic                 iptal;
   logic                 sifre_yukle;
   logic [SIFRE_W-1:0]   yeni_sifre;

   logic                 kilit_acik;
   logic                 hata;
   logic                 kilitli;
   logic [ADIM_NO_W-1:0] adim_no;
   logic [KALAN_W-1:0]   kalan_deneme;

   modport master (
      output adim_gecerli, yon, adim, iptal, sifre_yukle, yeni_sifre,
      input  kilit_acik, hata, kilitli, adim_no, kalan_deneme
   );

   modport slave (
      input  adim_gecerli, yon, adim, iptal, sifre_yukle, yeni_sifre,
      output kilit_acik, hata, kilitli, adim_no, kalan_deneme
   );
endinterface

// File: rtl/sirali_kilit_acici.sv
// Sequential combination-lock controller: compares a full sequence of dial moves
// against a reloadable code, with attempt counting, timed lockout and open window.
module sirali_kilit_acici #(
   parameter int ADIM_SAYISI  = 4,
   parameter int ADIM_W       = 3,
   parameter int DENEME_LIMIT = 3,
   parameter int KILIT_SURE   = 16,
   parameter int ACIK_SURE    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   sirali_kilit_acici_if.slave  bus
);
   localparam int HAMLE_W   = ADIM_W + 1;
   localparam int SIFRE_W   = ADIM_SAYISI * HAMLE_W;
   localparam int ADIM_NO_W = $clog2(ADIM_SAYISI + 1);
   localparam int KALAN_W   = $clog2(DENEME_LIMIT + 1);
   localparam int MAX_SURE  = (KILIT_SURE > ACIK_SURE) ? KILIT_SURE : ACIK_SURE;
   localparam int ZAMAN_W   = $clog2(MAX_SURE + 1);

   typedef enum logic [2:0] {
      BEKLE,
      GIRIS,
      ACIK,
      HATA,
      KILITLI
   } durum_t;

   durum_t               durum_reg;
   logic [SIFRE_W-1:0]   sifre_reg;
   logic [ADIM_NO_W-1:0] adim_no_reg;
   logic                 uyumsuz_reg;
   logic [KALAN_W-1:0]   kalan_deneme_reg;
   logic [ZAMAN_W-1:0]   zaman_reg;
   logic                 kilit_acik_reg;
   logic                 hata_reg;
   logic                 kilitli_reg;

   logic [HAMLE_W-1:0]     gelen_hamle;
   logic [ADIM_SAYISI-1:0] hamle_esit;
   logic [ADIM_SAYISI-1:0] hamle_sec;
   logic                   hamle_dogru;
   logic                   son_hamle;
   logic                   sonuc_uyumsuz;

   assign gelen_hamle = {bus.yon, bus.adim};

   // One equality comparator per stored move; adim_no picks which one counts.
   generate
      for (genvar gi = 0; gi < ADIM_SAYISI; gi++) begin : g_hamle
         assign hamle_esit[gi] = (sifre_reg[gi*HAMLE_W +: HAMLE_W] == gelen_hamle);
         assign hamle_sec[gi]  = (adim_no_reg == ADIM_NO_W'(gi));
      end
   endgenerate

   assign hamle_dogru   = |(hamle_esit & hamle_sec);
   assign son_hamle     = (adim_no_reg == ADIM_NO_W'(ADIM_SAYISI - 1));
   assign sonuc_uyumsuz = uyumsuz_reg | ~hamle_dogru;

   always_ff @(posedge clk) begin
      if (rst) begin
         durum_reg        <= BEKLE;
         sifre_reg        <= '0;
         adim_no_reg      <= '0;
         uyumsuz_reg      <= 1'b0;
         kalan_deneme_reg <= KALAN_W'(DENEME_LIMIT);
         zaman_reg        <= '0;
         kilit_acik_reg   <= 1'b0;
         hata_reg         <= 1'b0;
         kilitli_reg      <= 1'b0;
      end else begin
         case (durum_reg)
            BEKLE: begin
               if (bus.iptal) begin
                  adim_no_reg <= '0;
                  uyumsuz_reg <= 1'b0;
               end else if (bus.adim_gecerli) begin
                  uyumsuz_reg <= ~hamle_dogru;
                  adim_no_reg <= ADIM_NO_W'(1);
                  durum_reg   <= GIRIS;
               end
            end

            GIRIS: begin
               if (bus.iptal) begin
                  adim_no_reg <= '0;
                  uyumsuz_reg <= 1'b0;
                  durum_reg   <= BEKLE;
               end else if (bus.adim_gecerli) begin
                  if (son_hamle) begin
                     // Whole sequence consumed: verdict is taken on this edge.
                     adim_no_reg <= '0;
                     uyumsuz_reg <= 1'b0;
                     if (!sonuc_uyumsuz) begin
                        durum_reg        <= ACIK;
                        kilit_acik_reg   <= 1'b1;
                        zaman_reg        <= ZAMAN_W'(ACIK_SURE - 1);
                        kalan_deneme_reg <= KALAN_W'(DENEME_LIMIT);
                     end else if (kalan_deneme_reg > KALAN_W'(1)) begin
                        durum_reg        <= HATA;
                        hata_reg         <= 1'b1;
                        kalan_deneme_reg <= kalan_deneme_reg - KALAN_W'(1);
                     end else begin
                        durum_reg        <= KILITLI;
                        kilitli_reg      <= 1'b1;
                        zaman_reg        <= ZAMAN_W'(KILIT_SURE - 1);
                        kalan_deneme_reg <= '0;
                     end
                  end else begin
                     uyumsuz_reg <= sonuc_uyumsuz;
                     adim_no_reg <= adim_no_reg + ADIM_NO_W'(1);
                  end
               end
            end

            ACIK: begin
               if (bus.sifre_yukle) begin
                  sifre_reg <= bus.yeni_sifre;
               end
               if (zaman_reg == '0) begin
                  kilit_acik_reg <= 1'b0;
                  durum_reg      <= BEKLE;
               end else begin
                  zaman_reg <= zaman_reg - ZAMAN_W'(1);
               end
            end

            HATA: begin
               hata_reg  <= 1'b0;
               durum_reg <= BEKLE;
            end

            KILITLI: begin
               if (zaman_reg == '0) begin
                  kilitli_reg      <= 1'b0;
                  kalan_deneme_reg <= KALAN_W'(DENEME_LIMIT);
                  durum_reg        <= BEKLE;
               end else begin
                  zaman_reg <= zaman_reg - ZAMAN_W'(1);
               end
            end

            default: begin
               durum_reg      <= BEKLE;
               adim_no_reg    <= '0;
               uyumsuz_reg    <= 1'b0;
               kilit_acik_reg <= 1'b0;
               hata_reg       <= 1'b0;
               kilitli_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.kilit_acik   = kilit_acik_reg;
   assign bus.hata         = hata_reg;
   assign bus.kilitli      = kilitli_reg;
   assign bus.adim_no      = adim_no_reg;
   assign bus.kalan_deneme = kalan_deneme_reg;

endmodule

// File: tb/tb_sirali_kilit_acici.sv
// Directed bench for the sequential combination lock: open, reload, failures,
// lockout, abort, reset mid-operation and ignored reloads outside the open state.
module tb_sirali_kilit_acici;
   logic clk;
   logic rst;

   int n_assert;
   int n_fail;
   int cnt;
   logic [15:0] kod_v;
   logic [15:0] yanlis_v;

   sirali_kilit_acici_if #(.ADIM_SAYISI(4), .ADIM_W(3), .DENEME_LIMIT(3)) bus ();

   sirali_kilit_acici #(
      .ADIM_SAYISI(4), .ADIM_W(3), .DENEME_LIMIT(3), .KILIT_SURE(16), .ACIK_SURE(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic hamle(input logic y, input logic [2:0] a);
      bus.adim_gecerli = 1'b1;
      bus.yon          = y;
      bus.adim         = a;
      tick();
      bus.adim_gecerli = 1'b0;
   endtask

   // Enters all four moves of kod; bosluk[2k+:2] idle cycles follow move k.
   task automatic dizi(input logic [15:0] kod, input logic [7:0] bosluk);
      for (int k = 0; k < 4; k++) begin
         hamle(kod[k*4+3], kod[k*4 +: 3]);
         if (k < 3) idle(int'(bosluk[2*k +: 2]));
      end
   endtask

   // Counts open cycles from the current one; optionally reloads the code in the first.
   task automatic acik_bekle(input logic yukle, input logic [15:0] yeni, output int n);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (!bus.kilit_acik) break;
         n++;
         bus.sifre_yukle = yukle && (n == 1);
         bus.yeni_sifre  = yeni;
         tick();
      end
      bus.sifre_yukle = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      kod_v    = 16'h97B5;   // (sag,5),(sol,3),(sag,7),(sol,1)
      yanlis_v = 16'h9FB5;   // move 2 replaced by (sol,7)
      rst = 1'b1;
      bus.adim_gecerli = 1'b0;
      bus.yon          = 1'b0;
      bus.adim         = '0;
      bus.iptal        = 1'b0;
      bus.sifre_yukle  = 1'b0;
      bus.yeni_sifre   = '0;
      idle(2);
      chk("rst_kilit_acik", bus.kilit_acik, 0);
      chk("rst_hata", bus.hata, 0);
      chk("rst_kilitli", bus.kilitli, 0);
      chk("rst_adim_no", bus.adim_no, 0);
      chk("rst_kalan", bus.kalan_deneme, 3);
      rst = 1'b0;
      idle(1);

      // All-zero default code opens, then reload the new code while open.
      hamle(1'b0, 3'd0);
      hamle(1'b0, 3'd0);
      hamle(1'b0, 3'd0);
      chk("sifir_adim_no3", bus.adim_no, 3);
      chk("sifir_kapali", bus.kilit_acik, 0);
      hamle(1'b0, 3'd0);
      chk("sifir_acik", bus.kilit_acik, 1);
      chk("sifir_adim_no0", bus.adim_no, 0);
      chk("sifir_kalan", bus.kalan_deneme, 3);
      acik_bekle(1'b1, kod_v, cnt);
      chk("sifir_acik_sure", cnt, 8);
      chk("sifir_kalan_son", bus.kalan_deneme, 3);

      // New code with irregular gaps opens; window still exactly 8.
      hamle(kod_v[3], kod_v[2:0]);
      idle(1);
      hamle(kod_v[7], kod_v[6:4]);
      chk("bosluk_adim_no2", bus.adim_no, 2);
      idle(3);
      hamle(kod_v[11], kod_v[10:8]);
      hamle(kod_v[15], kod_v[14:12]);
      chk("yeni_acik", bus.kilit_acik, 1);
      acik_bekle(1'b0, '0, cnt);
      chk("yeni_acik_sure", cnt, 8);

      // Wrong move 2: no hata until the fourth move.
      hamle(yanlis_v[3], yanlis_v[2:0]);
      hamle(yanlis_v[7], yanlis_v[6:4]);
      hamle(yanlis_v[11], yanlis_v[10:8]);
      chk("yanlis_erken_hata", bus.hata, 0);
      hamle(yanlis_v[15], yanlis_v[14:12]);
      chk("yanlis1_hata", bus.hata, 1);
      chk("yanlis1_kalan", bus.kalan_deneme, 2);
      chk("yanlis1_kapali", bus.kilit_acik, 0);
      idle(1);
      chk("yanlis1_hata_tek", bus.hata, 0);

      dizi(yanlis_v, 8'h00);
      chk("yanlis2_hata", bus.hata, 1);
      chk("yanlis2_kalan", bus.kalan_deneme, 1);
      idle(1);
      dizi(yanlis_v, 8'h00);
      chk("yanlis3_hata_yok", bus.hata, 0);
      chk("yanlis3_kilitli", bus.kilitli, 1);
      chk("yanlis3_kalan", bus.kalan_deneme, 0);

      // Lockout ignores the correct code, iptal and reload.
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.kilitli) break;
         cnt++;
         bus.adim_gecerli = (i < 4);
         bus.yon          = kod_v[(i % 4)*4+3];
         bus.adim         = kod_v[(i % 4)*4 +: 3];
         bus.iptal        = (i == 5);
         bus.sifre_yukle  = (i == 6);
         bus.yeni_sifre   = '0;
         tick();
      end
      bus.adim_gecerli = 1'b0;
      bus.iptal        = 1'b0;
      bus.sifre_yukle  = 1'b0;
      chk("kilit_sure", cnt, 16);
      chk("kilit_sonra_kalan", bus.kalan_deneme, 3);
      chk("kilit_sonra_adim_no", bus.adim_no, 0);
      chk("kilit_sonra_acik", bus.kilit_acik, 0);
      dizi(kod_v, 8'h00);
      chk("kilit_sonra_dogru", bus.kilit_acik, 1);
      acik_bekle(1'b0, '0, cnt);
      chk("kilit_sonra_sure", cnt, 8);

      // iptal together with a valid move discards it and consumes no attempt.
      hamle(kod_v[3], kod_v[2:0]);
      hamle(kod_v[7], kod_v[6:4]);
      chk("iptal_once_adim_no", bus.adim_no, 2);
      bus.iptal = 1'b1;
      hamle(kod_v[11], kod_v[10:8]);
      bus.iptal = 1'b0;
      chk("iptal_adim_no", bus.adim_no, 0);
      chk("iptal_hata", bus.hata, 0);
      chk("iptal_kalan", bus.kalan_deneme, 3);
      idle(1);
      chk("iptal_hata_sonra", bus.hata, 0);
      dizi(kod_v, 8'h00);
      chk("iptal_sonra_acik", bus.kilit_acik, 1);
      acik_bekle(1'b0, '0, cnt);

      // Reset mid-entry restores the zero code.
      hamle(kod_v[3], kod_v[2:0]);
      hamle(kod_v[7], kod_v[6:4]);
      hamle(kod_v[11], kod_v[10:8]);
      chk("rst_giris_adim_no3", bus.adim_no, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_giris_adim_no", bus.adim_no, 0);
      chk("rst_giris_kalan", bus.kalan_deneme, 3);
      chk("rst_giris_acik", bus.kilit_acik, 0);
      dizi(kod_v, 8'h00);
      chk("rst_eski_kod_hata", bus.hata, 1);
      chk("rst_eski_kod_kalan", bus.kalan_deneme, 2);
      idle(1);
      dizi(16'h0000, 8'h00);
      chk("rst_sifir_acik", bus.kilit_acik, 1);
      chk("rst_sifir_kalan", bus.kalan_deneme, 3);

      // Reload while open, then reset during the open window.
      bus.sifre_yukle = 1'b1;
      bus.yeni_sifre  = kod_v;
      tick();
      bus.sifre_yukle = 1'b0;
      tick();
      chk("rst_acik_once", bus.kilit_acik, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_acik_kilit_acik", bus.kilit_acik, 0);
      chk("rst_acik_hata", bus.hata, 0);
      chk("rst_acik_kilitli", bus.kilitli, 0);
      chk("rst_acik_adim_no", bus.adim_no, 0);
      chk("rst_acik_kalan", bus.kalan_deneme, 3);
      dizi(kod_v, 8'h00);
      chk("rst_acik_eski_hata", bus.hata, 1);
      idle(1);
      dizi(16'h0000, 8'h00);
      chk("rst_acik_sifir_acik", bus.kilit_acik, 1);
      acik_bekle(1'b0, '0, cnt);
      chk("rst_acik_sure", cnt, 8);

      // Reload outside the open state is ignored.
      bus.sifre_yukle = 1'b1;
      bus.yeni_sifre  = kod_v;
      tick();
      bus.sifre_yukle = 1'b0;
      dizi(16'h0000, 8'h1B);
      chk("bekle_yukle_yok", bus.kilit_acik, 1);
      chk("bekle_yukle_hata", bus.hata, 0);
      acik_bekle(1'b0, '0, cnt);
      chk("bekle_yukle_sure", cnt, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
